// File: rtl/mem_pkg.sv
// mem_pkg: shared types and default widths for the mem_responder slice.
package mem_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic {OP_RD, OP_WR} op_t;
    localparam int ADDR_W_D = 9;
    localparam int DATA_W_D = 32;
endpackage

// File: rtl/mem_if.sv
// mem_if: MDR/MAR memory bus; MemErr exists only with MEM_CONFLICT_ERR_EN.
interface mem_if
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_D,
    parameter int DATA_W = DATA_W_D
);
    logic              Read;
    logic              Write;
    logic [ADDR_W-1:0] MAR;
    logic [DATA_W-1:0] MDataOut;
    logic [DATA_W-1:0] MDataIn;
    logic              MemReady;
    logic              Busy;
`ifdef MEM_CONFLICT_ERR_EN
    logic              MemErr;
    modport master (output Read, Write, MAR, MDataOut, input MDataIn, MemReady, Busy, MemErr);
    modport slave  (input Read, Write, MAR, MDataOut, output MDataIn, MemReady, Busy, MemErr);
`else
    modport master (output Read, Write, MAR, MDataOut, input MDataIn, MemReady, Busy);
    modport slave  (input Read, Write, MAR, MDataOut, output MDataIn, MemReady, Busy);
`endif
endinterface

// File: rtl/mem_array.sv
// mem_array: single-port synchronous RAM, read-first, contents not reset.
module mem_array #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: multi-cycle memory responder for the MDR/MAR interface.
// MEM_CONFLICT_ERR_EN rejects simultaneous Read&Write with a MemErr pulse.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_D,
    parameter int DATA_W  = DATA_W_D,
    parameter int LATENCY = 2
) (
    input logic  clock,
    input logic  clear,
    mem_if.slave bus
);
    state_t            state;
    op_t               op;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata, rdata;
    logic              req, done, conflict, err_q;
    assign req  = bus.Read | bus.Write;
    assign done = state == ACCESS && cnt == 4'd0;
`ifdef MEM_CONFLICT_ERR_EN
    assign conflict = bus.Read & bus.Write;
`else
    assign conflict = 1'b0;
`endif
    // Address the RAM from MAR while idle so read data is already registered when RESP is entered.
    mem_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem (
        .clk   (clock),
        .we    (done && op == OP_WR && !err_q),
        .addr  (state == IDLE ? bus.MAR : addr),
        .wdata (wdata),
        .rdata (rdata)
    );
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state        <= IDLE;
            op           <= OP_RD;
            cnt          <= 4'd0;
            addr         <= '0;
            wdata        <= '0;
            err_q        <= 1'b0;
            bus.MDataIn  <= '0;
            bus.MemReady <= 1'b0;
            bus.Busy     <= 1'b0;
`ifdef MEM_CONFLICT_ERR_EN
            bus.MemErr   <= 1'b0;
`endif
        end else begin
            bus.MemReady <= done && !err_q;
`ifdef MEM_CONFLICT_ERR_EN
            bus.MemErr   <= done && err_q;
`endif
            bus.Busy     <= state == IDLE ? req : state == ACCESS;
            if (done && op == OP_RD && !err_q) bus.MDataIn <= rdata;
            case (state)
                IDLE: if (req) begin
                    state <= ACCESS;
                    cnt   <= 4'(LATENCY);
                    addr  <= bus.MAR;
                    wdata <= bus.MDataOut;
                    op    <= bus.Read ? OP_RD : OP_WR;
                    err_q <= conflict;
                end
                ACCESS: if (cnt == 4'd0) state <= RESP; else cnt <= cnt - 4'd1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder at LATENCY=2 and LATENCY=0.
// Honors MEM_CONFLICT_ERR_EN for the conflict expectations.
module tb_mem_responder;
    logic clk = 0;
    logic clear;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_if #(.ADDR_W(9), .DATA_W(32)) ia ();
    mem_if #(.ADDR_W(9), .DATA_W(32)) ib ();
    mem_responder #(.ADDR_W(9), .DATA_W(32), .LATENCY(2)) dut_a (.clock(clk), .clear(clear), .bus(ia.slave));
    mem_responder #(.ADDR_W(9), .DATA_W(32), .LATENCY(0)) dut_b (.clock(clk), .clear(clear), .bus(ib.slave));

    logic err_a, err_b;
`ifdef MEM_CONFLICT_ERR_EN
    assign err_a = ia.MemErr;
    assign err_b = ib.MemErr;
    localparam logic        CONF_ERR  = 1'b1;
    localparam logic [31:0] CONF_DATA = 32'h12345678;
`else
    assign err_a = 1'b0;
    assign err_b = 1'b0;
    localparam logic        CONF_ERR  = 1'b0;
    localparam logic [31:0] CONF_DATA = 32'hDEADBEEF;
`endif

    typedef struct {logic [31:0] d; int due; logic e;} exp_t;
    exp_t qa[$];
    exp_t qb[$];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    task automatic set_bus(input int sel, input logic rd, input logic wr, input logic [8:0] a, input logic [31:0] d);
        if (sel == 0) begin
            ia.Read = rd; ia.Write = wr; ia.MAR = a; ia.MDataOut = d;
        end else begin
            ib.Read = rd; ib.Write = wr; ib.MAR = a; ib.MDataOut = d;
        end
    endtask

    function automatic logic busy(input int sel);
        return sel == 0 ? ia.Busy : ib.Busy;
    endfunction

    function automatic logic [31:0] mdata(input int sel);
        return sel == 0 ? ia.MDataIn : ib.MDataIn;
    endfunction

    task automatic push(input int sel, input logic [31:0] d, input int due, input logic e);
        exp_t x;
        x.d = d; x.due = due; x.e = e;
        if (sel == 0) qa.push_back(x); else qb.push_back(x);
    endtask

    task automatic wait_idle(input int sel);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy(sel) && (sel == 0 ? qa.size() : qb.size()) == 0) return;
        end
        chk("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    // Operands are scrambled right after acceptance so a design using live MAR/MDataOut misbehaves.
    task automatic req(input int sel, input logic rd, input logic wr, input logic [8:0] a,
                       input logic [31:0] d, input logic [31:0] exp_d, input logic exp_e);
        int lat = sel == 0 ? 2 : 0;
        @(negedge clk);
        set_bus(sel, rd, wr, a, d);
        @(posedge clk);
        #1;
        push(sel, exp_d, cyc + lat + 1, exp_e);
        chk("busy_after_accept", 32'(busy(sel)), 32'd1);
        set_bus(sel, 1'b0, 1'b0, a ^ 9'h1FA, ~d);
        wait_idle(sel);
    endtask

    task automatic mon(input string n, input logic rdy, input logic er, input logic [31:0] md, inout exp_t q[$]);
        exp_t e;
        if (q.size() == 0) begin
            chk({n, "_unexpected_resp"}, {rdy, er}, 32'd0);
        end else begin
            e = q.pop_front();
            chk({n, "_resp_cycle"}, cyc, e.due);
            chk({n, "_ready_err"}, {rdy, er}, {!e.e, e.e});
            chk({n, "_mdatain"}, md, e.d);
        end
    endtask

    always @(negedge clk) if (ia.MemReady || err_a) mon("a", ia.MemReady, err_a, ia.MDataIn, qa);
    always @(negedge clk) if (ib.MemReady || err_b) mon("b", ib.MemReady, err_b, ib.MDataIn, qb);

    initial begin
        clear = 1;
        set_bus(0, 0, 0, 9'h0, 32'h0);
        set_bus(1, 0, 0, 9'h0, 32'h0);
        #2 clear = 0;
        #1;
        for (int s = 0; s < 2; s++) begin
            chk("rst_busy", 32'(busy(s)), 32'd0);
            chk("rst_mdatain", mdata(s), 32'd0);
        end
        chk("rst_ready_a", 32'(ia.MemReady), 32'd0);
        chk("rst_ready_b", 32'(ib.MemReady), 32'd0);
        repeat (2) @(negedge clk);
        clear = 1;
        // Write, read back, hold after MemReady falls.
        req(0, 0, 1, 9'h005, 32'hDEADBEEF, 32'h0, 1'b0);
        chk("write_keeps_mdatain", mdata(0), 32'h0);
        req(0, 1, 0, 9'h005, 32'h0, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        chk("read_hold", mdata(0), 32'hDEADBEEF);
        // Back-to-back: write held high through RESP, then read accepted in the IDLE cycle.
        @(negedge clk);
        set_bus(0, 0, 1, 9'h1FF, 32'h00000011);
        @(posedge clk);
        #1;
        push(0, 32'hDEADBEEF, cyc + 3, 1'b0);
        set_bus(0, 0, 1, 9'h005, 32'hFFFFFFEE);
        for (int i = 0; i < 20 && !ia.MemReady; i++) @(negedge clk);
        chk("b2b_first_ready", 32'(ia.MemReady), 32'd1);
        @(negedge clk);
        set_bus(0, 1, 0, 9'h1FF, 32'h0);
        @(posedge clk);
        #1;
        push(0, 32'h00000011, cyc + 3, 1'b0);
        set_bus(0, 0, 0, 9'h005, 32'h0);
        wait_idle(0);
        // Stability: MAR scrambles to 0x1FF (holding 0x11) during ACCESS.
        req(0, 1, 0, 9'h005, 32'h0, 32'hDEADBEEF, 1'b0);
        req(0, 0, 1, 9'h010, 32'h12345678, 32'hDEADBEEF, 1'b0);
        // Abort a write mid-ACCESS with reset.
        @(negedge clk);
        set_bus(0, 0, 1, 9'h010, 32'hCAFEF00D);
        @(posedge clk);
        #1;
        set_bus(0, 0, 0, 9'h010, 32'h0);
        @(negedge clk);
        clear = 0;
        #1;
        chk("abort_busy", 32'(ia.Busy), 32'd0);
        chk("abort_mdatain", ia.MDataIn, 32'd0);
        @(negedge clk);
        clear = 1;
        repeat (5) @(negedge clk);
        req(0, 1, 0, 9'h010, 32'h0, 32'h12345678, 1'b0);
        // Conflict, then confirm memory untouched.
        req(0, 1, 1, 9'h005, 32'hBAD0BAD0, CONF_DATA, CONF_ERR);
        req(0, 1, 0, 9'h005, 32'h0, 32'hDEADBEEF, 1'b0);
        // LATENCY=0 instance.
        req(1, 0, 1, 9'h033, 32'hA5A5A5A5, 32'h0, 1'b0);
        req(1, 1, 0, 9'h033, 32'h0, 32'hA5A5A5A5, 1'b0);
        req(1, 1, 1, 9'h033, 32'h0F0F0F0F, 32'hA5A5A5A5, CONF_ERR);
        repeat (3) @(negedge clk);
        chk("queue_a_empty", qa.size(), 32'd0);
        chk("queue_b_empty", qb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the datapath's MDR/MAR memory interface.
- Accepts Read/Write requests carrying address (MAR) and write data (MDR), then holds a configurable number of wait cycles.
- Returns read data on MDataIn with a one-cycle MemReady pulse.
- Supplies the MDataIn word that the MDR loads when its Read select is high, so the datapath runs against a realistic multi-cycle memory.

Parameters:
- ADDR_W, 9, address width; memory depth is 2**ADDR_W words.
- DATA_W, 32, word width; matches the bus width.
- LATENCY, 2, number of wait cycles in ACCESS before responding; legal range 0..15.

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  asynchronous active-low reset.
- Read  in  1  read request level.
- Write  in  1  write request level.
- MAR  in  ADDR_W  word address.
- MDataOut  in  DATA_W  write data from the MDR.
- MDataIn  out  DATA_W  read data to the MDR.
- MemReady  out  1  one-cycle completion pulse.
- Busy  out  1  high while a request is in flight.

Behaviour:
- Reset (clear=0, asynchronous): state=IDLE, MDataIn=0, MemReady=0, Busy=0, wait counter=0. Memory array contents are not reset.
- States:
  - IDLE: Busy=0. At a rising edge with Read|Write high, the request is accepted: MAR, MDataOut and the op are latched; wait counter is set to LATENCY; state goes to ACCESS.
  - ACCESS: Busy=1. If counter==0, go to RESP; otherwise decrement the counter.
  - RESP: Busy=1 and MemReady=1 for exactly one cycle. Unconditionally return to IDLE at the next edge.
- Latency: for a request accepted at edge t, RESP is entered at edge t+LATENCY+1, so MemReady is high in the cycle after that edge. With LATENCY=0, MemReady is high one cycle after acceptance.
- Read: the memory word at the latched address is loaded into MDataIn on the edge entering RESP. MDataIn holds that value until the next read completes; writes do not change it.
- Write: the latched data is written to the latched address on the edge entering RESP.
- Read and Write are sampled only in IDLE. Changes to MAR, MDataOut, Read or Write during ACCESS or RESP are ignored; the operands latched at acceptance are used.
- The requester deasserts Read/Write after MemReady. If a request is still high in the IDLE cycle after RESP, it is accepted as a new request (back-to-back).
- Simultaneous Read and Write at acceptance: Read wins when the optional feature is absent.
- Reset mid-operation: the access is abandoned, no write occurs, and outputs return to their reset values.
- Address wrap is not possible; every ADDR_W value maps to a valid word.

Optional Feature:
- Macro: MEM_CONFLICT_ERR_EN.
- Defined:
  - Adds output MemErr (1 bit, reset 0).
  - Read&Write both high at acceptance is rejected: state goes to RESP with no access.
  - In that RESP cycle MemErr=1 and MemReady=0; MDataIn and memory contents are unchanged. Total latency is the same as a normal request.
- Undefined: no MemErr port; read priority applies as described above.

Decomposition:
- Package mem_pkg:
  - state enum {IDLE, ACCESS, RESP};
  - default ADDR_W/DATA_W constants;
  - op encoding {OP_RD, OP_WR}.
- Sub-module mem_array: single-port synchronous RAM (DATA_W x 2**ADDR_W) with we, addr, wdata, rdata; no reset on contents. mem_responder instantiates one mem_array and contains the FSM and counter.

Test Plan:
- Reset then write:
  - Stimulus: reset asserted, then Write=1, MAR=0x005, MDataOut=0xDEADBEEF, LATENCY=2.
  - Response: Busy=1 starting the cycle after acceptance; MemReady pulses exactly 3 edges after acceptance; MDataIn stays 0.
- Read back:
  - Stimulus: Read=1, MAR=0x005.
  - Response: MDataIn=0xDEADBEEF in the same cycle MemReady=1; the value holds after MemReady falls.
- Operand stability:
  - Stimulus: Read accepted at MAR=0x005, then MAR changed to 0x1FF during ACCESS.
  - Response: data returned is still from 0x005.
- Back-to-back:
  - Stimulus: Write 0x00000011 to 0x1FF, keeping Write high through RESP; then Read 0x1FF.
  - Response: two MemReady pulses separated by LATENCY+2 cycles; the read returns 0x00000011.
- Reset mid-access:
  - Stimulus: clear low during ACCESS of a write of 0xCAFEF00D to 0x010.
  - Response: MemReady never pulses; a later read of 0x010 returns the prior contents.
- LATENCY=0 and conflict:
  - Stimulus: LATENCY=0, Read accepted.
  - Response: MemReady one cycle after acceptance.
  - Stimulus: Read&Write both high.
  - Response: read result without MEM_CONFLICT_ERR_EN; with it, MemErr=1, MemReady=0, memory unchanged.
